// File: rtl/rca_config_loader.sv
// Descriptor-driven loader: parses a header plus N entry words and issues each valid
// entry as one handshaked configuration write toward the selected RCA's config storage.
module rca_config_loader #(
    parameter int NUM_RCAS        = 2,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2,
    localparam int RCA_SEL_W      = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [31:0]          desc_data,
    output logic                 cfg_valid,
    input  logic                 cfg_ready,
    output logic [2:0]           cfg_kind,
    output logic [RCA_SEL_W-1:0] cfg_rca_sel,
    output logic [12:0]          cfg_addr,
    output logic [15:0]          cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           entries_issued
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        ENTRY  = 3'd2,
        ISSUE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0]  KIND_SRC_REG  = 3'd0;
    localparam logic [2:0]  KIND_DEST_REG = 3'd1;
    localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
    localparam logic [13:0] READ_LIM      = 14'(NUM_READ_PORTS);
    localparam logic [13:0] WRITE_LIM     = 14'(NUM_WRITE_PORTS);

    state_t                 r_state;
    logic                   r_desc_ready;
    logic                   r_cfg_valid;
    logic [2:0]             r_cfg_kind;
    logic [RCA_SEL_W-1:0]   r_cfg_rca_sel;
    logic [12:0]            r_cfg_addr;
    logic [15:0]            r_cfg_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [7:0]             r_issued;
    logic [7:0]             r_remain;

    logic [2:0]             w_kind;
    logic [12:0]            w_addr;
    logic [15:0]            w_data;
    logic [7:0]             w_hdr_count;
    logic [RCA_SEL_W-1:0]   w_hdr_sel;
    logic                   w_hdr_ok;
    logic                   w_entry_bad;
    logic                   w_desc_fire;
    logic                   w_last;
    logic                   w_unused_hdr;

    assign w_kind      = desc_data[31:29];
    assign w_addr      = desc_data[28:16];
    assign w_data      = desc_data[15:0];
    assign w_hdr_count = desc_data[7:0];
    assign w_hdr_sel   = desc_data[8 +: RCA_SEL_W];
    assign w_hdr_ok    = (desc_data[31:24] == HDR_MAGIC);
    assign w_unused_hdr = ^{desc_data[23:16], desc_data[15:8]};

    assign w_entry_bad = (w_kind == 3'd6) || (w_kind == 3'd7)
                      || ((w_kind == KIND_SRC_REG)  && ({1'b0, w_addr} >= READ_LIM))
                      || ((w_kind == KIND_DEST_REG) && ({1'b0, w_addr} >= WRITE_LIM));

    // desc_ready is a register, so this handshake term never feeds an output combinationally
    assign w_desc_fire = desc_valid && r_desc_ready;
    assign w_last      = (r_remain == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_desc_ready  <= 1'b0;
            r_cfg_valid   <= 1'b0;
            r_cfg_kind    <= '0;
            r_cfg_rca_sel <= '0;
            r_cfg_addr    <= '0;
            r_cfg_data    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_issued      <= '0;
            r_remain      <= '0;
        end else if (r_state == IDLE) begin
            r_done <= 1'b0;
            if (start && !abort) begin
                r_state      <= HEADER;
                r_busy       <= 1'b1;
                r_desc_ready <= 1'b1;
                r_err        <= 1'b0;
                r_issued     <= '0;
            end
        end else if (abort) begin
            // err and the issued count deliberately survive an abort
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_desc_ready <= 1'b0;
            r_cfg_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                HEADER: begin
                    if (w_desc_fire) begin
                        if (!w_hdr_ok) begin
                            r_err        <= 1'b1;
                            r_state      <= DONE;
                            r_desc_ready <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_cfg_rca_sel <= w_hdr_sel;
                            r_remain      <= w_hdr_count;
                            if (w_hdr_count == 8'd0) begin
                                r_state      <= DONE;
                                r_desc_ready <= 1'b0;
                                r_done       <= 1'b1;
                            end else begin
                                r_state <= ENTRY;
                            end
                        end
                    end
                end
                ENTRY: begin
                    if (w_desc_fire) begin
                        if (w_entry_bad) begin
                            r_err    <= 1'b1;
                            r_remain <= r_remain - 8'd1;
                            if (w_last) begin
                                r_state      <= DONE;
                                r_desc_ready <= 1'b0;
                                r_done       <= 1'b1;
                            end
                        end else begin
                            r_cfg_kind   <= w_kind;
                            r_cfg_addr   <= w_addr;
                            r_cfg_data   <= w_data;
                            r_cfg_valid  <= 1'b1;
                            r_desc_ready <= 1'b0;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cfg_ready) begin
                        r_cfg_valid <= 1'b0;
                        r_remain    <= r_remain - 8'd1;
                        if (r_issued != 8'hFF) begin
                            r_issued <= r_issued + 8'd1;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ENTRY;
                            r_desc_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_desc_ready <= 1'b0;
                    r_cfg_valid  <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign desc_ready     = r_desc_ready;
    assign cfg_valid      = r_cfg_valid;
    assign cfg_kind       = r_cfg_kind;
    assign cfg_rca_sel    = r_cfg_rca_sel;
    assign cfg_addr       = r_cfg_addr;
    assign cfg_data       = r_cfg_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign entries_issued = r_issued;

endmodule

// File: tb/tb_rca_config_loader.sv
// Bench for rca_config_loader: directed and random descriptor loads checked against a
// descriptor-level model of the expected write list, error flag and issued count.
module tb_rca_config_loader;

    localparam int NUM_RCAS        = 2;
    localparam int NUM_READ_PORTS  = 5;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int RCA_SEL_W       = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic                 desc_valid;
    logic                 desc_ready;
    logic [31:0]          desc_data;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [2:0]           cfg_kind;
    logic [RCA_SEL_W-1:0] cfg_rca_sel;
    logic [12:0]          cfg_addr;
    logic [15:0]          cfg_data;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [7:0]           entries_issued;

    int          n_cmp;
    int          n_bad;
    logic [31:0] q_desc[$];

    rca_config_loader #(
        .NUM_RCAS        (NUM_RCAS),
        .NUM_READ_PORTS  (NUM_READ_PORTS),
        .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_data      (desc_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_kind       (cfg_kind),
        .cfg_rca_sel    (cfg_rca_sel),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .entries_issued (entries_issued)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  64'(busy), 64'd0);
        check_val({tag, "_done"},  64'(done), 64'd0);
        check_val({tag, "_err"},   64'(err), 64'd0);
        check_val({tag, "_cfgv"},  64'(cfg_valid), 64'd0);
        check_val({tag, "_drdy"},  64'(desc_ready), 64'd0);
        check_val({tag, "_cnt"},   64'(entries_issued), 64'd0);
        check_val({tag, "_kind"},  64'(cfg_kind), 64'd0);
        check_val({tag, "_sel"},   64'(cfg_rca_sel), 64'd0);
        check_val({tag, "_addr"},  64'(cfg_addr), 64'd0);
        check_val({tag, "_data"},  64'(cfg_data), 64'd0);
    endtask

    // ready_mode: 0 random cfg_ready, 1 always ready, 2 first ten ISSUE cycles stalled
    task automatic run_load(input int ready_mode, input string name);
        logic [63:0]          exp_w[$];
        logic [63:0]          got_w[$];
        bit                   exp_err;
        int                   exp_consumed;
        int                   exp_issued;
        logic [31:0]          hdr;
        logic [31:0]          w;
        logic [RCA_SEL_W-1:0] sel;
        logic [2:0]           kind;
        logic [12:0]          addr;
        int                   n;
        int                   idx;
        int                   dones;
        int                   last_evt;
        int                   stall;
        bit                   finished;
        bit                   prev_valid;
        bit                   prev_fire;
        bit                   d_fire;
        bit                   c_fire;
        logic [63:0]          prev_pl;
        logic [63:0]          pl;

        hdr = q_desc[0];
        exp_err = 1'b0;
        if (hdr[31:24] != 8'hA5) begin
            exp_err      = 1'b1;
            exp_consumed = 1;
        end else begin
            sel          = hdr[8 +: RCA_SEL_W];
            n            = int'(hdr[7:0]);
            exp_consumed = 1 + n;
            for (int i = 1; i <= n; i++) begin
                w    = q_desc[i];
                kind = w[31:29];
                addr = w[28:16];
                if (kind >= 3'd6 || (kind == 3'd0 && int'(addr) >= NUM_READ_PORTS)
                    || (kind == 3'd1 && int'(addr) >= NUM_WRITE_PORTS)) begin
                    exp_err = 1'b1;
                end else begin
                    exp_w.push_back(64'({kind, sel, addr, w[15:0]}));
                end
            end
        end
        exp_issued = (exp_w.size() > 255) ? 255 : exp_w.size();

        idx = 0; dones = 0; last_evt = -1; stall = 0; finished = 1'b0;
        prev_valid = 1'b0; prev_fire = 1'b0; prev_pl = '0;
        start = 1'b1; desc_valid = 1'b0; cfg_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({name, "_busy_after_start"}, 64'(busy), 64'd1);
        check_val({name, "_err_cleared"}, 64'(err), 64'd0);
        check_val({name, "_cnt_cleared"}, 64'(entries_issued), 64'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            pl = 64'({cfg_kind, cfg_rca_sel, cfg_addr, cfg_data});
            if (prev_valid && !prev_fire) begin
                check_val({name, "_valid_hold"}, 64'(cfg_valid), 64'd1);
                check_val({name, "_payload_stable"}, pl, prev_pl);
            end
            if (cfg_valid) check_val({name, "_drdy_in_issue"}, 64'(desc_ready), 64'd0);
            if (done) begin
                dones++;
                check_val({name, "_done_timing"}, 64'(cyc), 64'(last_evt + 1));
            end
            if (dones > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            desc_valid = (idx < q_desc.size()) && ($urandom_range(0, 3) != 0);
            desc_data  = (idx < q_desc.size()) ? q_desc[idx] : $urandom;
            case (ready_mode)
                1:       cfg_ready = 1'b1;
                2: begin
                    cfg_ready = 1'b0;
                    if (cfg_valid) begin
                        cfg_ready = (stall >= 10);
                        stall++;
                    end
                end
                default: cfg_ready = 1'($urandom_range(0, 1));
            endcase
            start  = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            d_fire = desc_valid && desc_ready;
            c_fire = cfg_valid && cfg_ready;
            if (d_fire) begin
                idx++;
                last_evt = cyc;
            end
            if (c_fire) begin
                got_w.push_back(pl);
                last_evt = cyc;
            end
            prev_valid = cfg_valid;
            prev_fire  = c_fire;
            prev_pl    = pl;
            @(posedge clk); #1;
        end
        start = 1'b0; desc_valid = 1'b0; cfg_ready = 1'b0;

        check_val({name, "_finished"}, 64'(finished), 64'd1);
        check_val({name, "_done_count"}, 64'(dones), 64'd1);
        check_val({name, "_consumed"}, 64'(idx), 64'(exp_consumed));
        check_val({name, "_write_count"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            check_val({name, "_write"}, got_w[i], exp_w[i]);
        end
        check_val({name, "_err"}, 64'(err), 64'(exp_err));
        check_val({name, "_issued"}, 64'(entries_issued), 64'(exp_issued));
        $display("load %s: hdr=%08h words_used=%0d writes=%0d err=%0b issued=%0d",
                 name, hdr, idx, got_w.size(), err, entries_issued);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        desc_valid = 1'b0; desc_data = '0; cfg_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("idle_after_por", 64'(busy), 64'd0);

        q_desc = '{32'hA5000102, 32'h00020003, 32'h40050011, 32'hDEADBEEF};
        run_load(1, "two_writes");
        q_desc = '{32'hA5000000, 32'h12345678};
        run_load(0, "empty");
        q_desc = '{32'h5A000003, 32'h00010001, 32'h00020002, 32'h00030003};
        run_load(0, "bad_magic");
        q_desc = '{32'hA5000003, 32'h00010001, 32'hE0030004, 32'h00070005, 32'h0};
        run_load(0, "bad_entries");
        q_desc = '{32'hA5000101, 32'h60030044, 32'hCAFEF00D};
        run_load(2, "stall");

        // abort+start together in IDLE must stay idle
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check_val("abort_start_idle_busy", 64'(busy), 64'd0);
        check_val("abort_start_idle_drdy", 64'(desc_ready), 64'd0);

        // abort during a stalled ISSUE, after one write and one bad entry
        begin
            int idx;
            bit reached;
            q_desc = '{32'hA5000103, 32'h40050011, 32'hE0000000, 32'h00010007};
            idx = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            reached = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (cfg_valid && entries_issued == 8'd1) begin
                    reached = 1'b1;
                    break;
                end
                desc_valid = (idx < q_desc.size());
                desc_data  = (idx < q_desc.size()) ? q_desc[idx] : 32'h0;
                cfg_ready  = (entries_issued == 8'd0);
                if (desc_valid && desc_ready) idx++;
                @(posedge clk); #1;
            end
            desc_valid = 1'b0; cfg_ready = 1'b0;
            check_val("abort_reach_issue", 64'(reached), 64'd1);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check_val("abort_cfgv", 64'(cfg_valid), 64'd0);
            check_val("abort_busy", 64'(busy), 64'd0);
            check_val("abort_drdy", 64'(desc_ready), 64'd0);
            check_val("abort_err_held", 64'(err), 64'd1);
            check_val("abort_cnt_held", 64'(entries_issued), 64'd1);
            for (int i = 0; i < 3; i++) begin
                check_val("abort_no_done", 64'(done), 64'd0);
                @(posedge clk); #1;
            end
            $display("load abort: write_count=%0d err=%0b", entries_issued, err);
        end

        // reset asserted mid-load, between clock edges
        begin
            int idx;
            q_desc = '{32'hA5000102, 32'h00020003, 32'h40050011};
            idx = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 100 && !cfg_valid; i++) begin
                desc_valid = (idx < q_desc.size());
                desc_data  = (idx < q_desc.size()) ? q_desc[idx] : 32'h0;
                cfg_ready  = 1'b0;
                if (desc_valid && desc_ready) idx++;
                @(posedge clk); #1;
            end
            desc_valid = 1'b0;
            check_val("rst_mid_reach_issue", 64'(cfg_valid), 64'd1);
            #3 rst_n = 1'b0;
            #1 check_reset_outputs("rst_mid");
            #2 rst_n = 1'b1;
            @(posedge clk); #1;
            check_val("rst_mid_idle", 64'(busy), 64'd0);
            $display("load reset_mid: discarded");
        end
        q_desc = '{32'hA5000102, 32'h00020003, 32'h40050011, 32'hDEADBEEF};
        run_load(0, "after_reset");

        for (int t = 0; t < 40; t++) begin
            int nent;
            logic [31:0] hw;
            logic [2:0]  k;
            logic [12:0] a;
            nent = $urandom_range(0, 6);
            hw = {(($urandom_range(0, 9) == 0) ? 8'h5A : 8'hA5), 8'($urandom),
                  8'($urandom), 8'(nent)};
            q_desc = {};
            q_desc.push_back(hw);
            for (int i = 0; i < nent + 2; i++) begin
                k = 3'($urandom_range(0, 7));
                a = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 8));
                q_desc.push_back({k, a, 16'($urandom)});
            end
            run_load(t % 5 == 0 ? 1 : 0, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
